// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Uses one shift-add (MUL) or restoring shift-subtract (DIV) step per clock, WIDTH steps per operation.
module muldiv_hilo_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   mag_a_reg, mag_a_next;
    logic [WIDTH-1:0]   mag_b_reg, mag_b_next;
    logic               neg_res_reg, neg_res_next;
    logic               sign_a_reg, sign_a_next;
    logic [2*WIDTH-1:0] p_reg, p_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;
    logic               dz_reg, dz_next;

    // Operand signs and magnitudes (only signed ops see a sign).
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    assign sa    = op_reg[0] & a_reg[WIDTH-1];
    assign sb    = op_reg[0] & b_reg[WIDTH-1];
    assign abs_a = sa ? ({WIDTH{1'b0}} - a_reg) : a_reg;
    assign abs_b = sb ? ({WIDTH{1'b0}} - b_reg) : b_reg;

    // Multiply step: p holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, mag_a_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, p_reg[WIDTH-1:1]};

    // Divide step: p holds {remainder, dividend bits shifting into quotient bits}.
    logic [WIDTH:0]     div_top;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;
    assign div_top  = p_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff = {1'b0, div_top} - {2'b00, mag_b_reg};
    assign div_step = div_diff[WIDTH+1] ? {div_top[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div_zero;
    assign prod_fix = neg_res_reg ? ({(2*WIDTH){1'b0}} - p_reg) : p_reg;
    assign quo_fix  = neg_res_reg ? ({WIDTH{1'b0}} - p_reg[WIDTH-1:0]) : p_reg[WIDTH-1:0];
    assign rem_fix  = sign_a_reg ? ({WIDTH{1'b0}} - p_reg[2*WIDTH-1:WIDTH]) : p_reg[2*WIDTH-1:WIDTH];
    assign div_zero = op_reg[1] && (mag_b_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        mag_a_next   = mag_a_reg;
        mag_b_next   = mag_b_reg;
        neg_res_next = neg_res_reg;
        sign_a_next  = sign_a_reg;
        p_next       = p_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = 1'b0;
        dz_next      = dz_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next    = op;
                    a_next     = a;
                    b_next     = b;
                    state_next = PREP;
                end else begin
                    if (hi_wr) hi_next = wr_data;
                    if (lo_wr) lo_next = wr_data;
                end
            end
            PREP: begin
                mag_a_next   = abs_a;
                mag_b_next   = abs_b;
                sign_a_next  = sa;
                neg_res_next = sa ^ sb;
                cnt_next     = '0;
                p_next       = op_reg[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                state_next   = (op_reg[1] && (b_reg == '0)) ? FIX : RUN;
            end
            RUN: begin
                p_next   = op_reg[1] ? div_step : mul_step;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                if (div_zero) begin
                    lo_next = {WIDTH{1'b1}};
                    hi_next = a_reg;
                end else if (op_reg[1]) begin
                    lo_next = quo_fix;
                    hi_next = rem_fix;
                end else begin
                    lo_next = prod_fix[WIDTH-1:0];
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                end
                dz_next    = div_zero;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            mag_a_reg   <= '0;
            mag_b_reg   <= '0;
            neg_res_reg <= 1'b0;
            sign_a_reg  <= 1'b0;
            p_reg       <= '0;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
            dz_reg      <= 1'b0;
        end else begin
            op_reg      <= op_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            mag_a_reg   <= mag_a_next;
            mag_b_reg   <= mag_b_next;
            neg_res_reg <= neg_res_next;
            sign_a_reg  <= sign_a_next;
            p_reg       <= p_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
            dz_reg      <= dz_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign dz     = dz_reg;
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized and directed bench for muldiv_hilo_unit against an arithmetic reference model.
module tb_muldiv_hilo_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         hi_wr = 1'b0, lo_wr = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi_out, lo_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int e0 = 0;
    logic [W-1:0] hold_hi, hold_lo;

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .dz(dz), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference result {dz, hi, lo} from plain integer arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p, q, r;
        sx = o[0] ? longint'($signed(x)) : longint'(x);
        sy = o[0] ? longint'($signed(y)) : longint'(y);
        if (!o[1]) begin
            p = sx * sy;
            return {1'b0, p[2*W-1:0]};
        end
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    // Called #1 after a rising edge with the unit idle (or in its done cycle).
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        hold_hi = hi_out;
        hold_lo = lo_out;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input bit check_drop);
        logic [2*W:0] exp_r;
        bit got, chg;
        int lat, exp_lat;
        exp_r = model(o, x, y);
        exp_lat = (o[1] && y == '0) ? 2 : W + 2;
        got = 0; chg = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (done) got = 1;
            else if (hi_out !== hold_hi || lo_out !== hold_lo) chg = 1;
        end
        lat = cyc - e0;
        check({tag, " done_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " hi"}, 64'(hi_out), 64'(exp_r[2*W-1:W]));
        check({tag, " lo"}, 64'(lo_out), 64'(exp_r[W-1:0]));
        check({tag, " dz"}, 64'(dz), 64'(exp_r[2*W]));
        check({tag, " hilo_held"}, 64'(chg), 64'd0);
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
                 tag, o, x, y, hi_out, lo_out, dz, lat);
        if (check_drop) begin
            @(posedge clk); #1;
            check({tag, " done_drop"}, 64'(done), 64'd0);
            check({tag, " dz_hold"}, 64'(dz), 64'(exp_r[2*W]));
            check({tag, " busy_idle"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int dseen;

        #2;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst dz", 64'(dz), 64'd0);
        check("rst hi", 64'(hi_out), 64'd0);
        check("rst lo", 64'(lo_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Direct HI/LO writes while idle.
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 16'h5A5A;
        @(posedge clk); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthilo hi", 64'(hi_out), 64'h5A5A);
        check("mthilo lo", 64'(lo_out), 64'h5A5A);
        $display("txn mthilo wr=5a5a -> hi=%h lo=%h", hi_out, lo_out);

        issue(2'b00, 16'hFFFF, 16'hFFFF); wait_done("mulu_max", 2'b00, 16'hFFFF, 16'hFFFF, 1);
        issue(2'b01, 16'hFFFD, 16'h0007); wait_done("muls", 2'b01, 16'hFFFD, 16'h0007, 1);
        issue(2'b11, 16'hFFF9, 16'h0002); wait_done("divs", 2'b11, 16'hFFF9, 16'h0002, 1);
        issue(2'b11, 16'h8000, 16'hFFFF); wait_done("divs_ovf", 2'b11, 16'h8000, 16'hFFFF, 1);
        issue(2'b10, 16'h1234, 16'h0000); wait_done("divu_dz", 2'b10, 16'h1234, 16'h0000, 1);

        // Start and HI/LO writes during RUN are ignored; next op starts in the done cycle.
        issue(2'b00, 16'h1357, 16'h2468);
        repeat (5) @(posedge clk);
        #1;
        op = 2'b10; a = 16'h0F0F; b = 16'h0003; start = 1'b1;
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 16'hAAAA;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        wait_done("midrun", 2'b00, 16'h1357, 16'h2468, 0);
        issue(2'b11, 16'h7FFF, 16'hFFFD); wait_done("b2b", 2'b11, 16'h7FFF, 16'hFFFD, 1);

        // Write ignored on the edge a start is accepted.
        hi_wr = 1'b1; wr_data = 16'hBEEF;
        issue(2'b00, 16'h0003, 16'h0005);
        hi_wr = 1'b0;
        wait_done("wr_on_start", 2'b00, 16'h0003, 16'h0005, 1);

        // Reset mid-RUN aborts with no done pulse.
        issue(2'b01, 16'h1234, 16'h4321);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort hi", 64'(hi_out), 64'd0);
        check("abort lo", 64'(lo_out), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort dz", 64'(dz), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dseen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) dseen++;
        end
        check("abort no_done", 64'(dseen), 64'd0);
        $display("txn abort -> hi=%h lo=%h busy=%0d done_pulses=%0d", hi_out, lo_out, busy, dseen);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 5) == 0) rb = (W'(1) << (W - 1));
            issue(ro, ra, rb);
            wait_done($sformatf("rnd%0d", n), ro, ra, rb, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/HI/LO width; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only on an edge where busy=0.
REQ-005 SHALL have port op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS; sampled with start.
REQ-006 SHALL have ports a, b  input  WIDTH  multiplicand/dividend (a), multiplier/divisor (b); sampled with start.
REQ-007 SHALL have ports hi_wr, lo_wr  input  1  direct write of wr_data into HI/LO (move-to-HI/LO).
REQ-008 SHALL have port wr_data  input  WIDTH  data for hi_wr/lo_wr.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse: HI/LO hold a new result.
REQ-011 SHALL have port dz  output  1  divide-by-zero flag, updated with done.
REQ-012 SHALL have ports hi_out, lo_out  output  WIDTH  registered HI and LO.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, RUN, FIX; busy=1 in PREP, RUN, FIX.
REQ-014 SHALL, in IDLE with start=1, latch op/a/b and go to PREP on that edge (accept edge E0).
REQ-015 SHALL in PREP form operand magnitudes (signed ops: two's-complement abs; unsigned: as-is), record signs, clear iteration counter, go to RUN; DIV with b=0 goes directly to FIX.
REQ-016 SHALL in RUN perform one iteration per edge for exactly WIDTH edges: shift-add for MUL (2*WIDTH-bit product), restoring shift-subtract for DIV; then go to FIX.
REQ-017 SHALL in FIX apply sign correction, write HI/LO, set done=1 and dz, return to IDLE, all on one edge.
REQ-018 SHALL produce done at edge E0+WIDTH+2 (observed high in the following cycle) for non-zero-divisor ops; busy falls on that same edge.
REQ-019 SHALL for MUL write HI = product[2*WIDTH-1:WIDTH], LO = product[WIDTH-1:0]; MULS product negated when sign(a) xor sign(b).
REQ-020 SHALL for DIV write LO = quotient, HI = remainder; DIVS quotient negated when sign(a) xor sign(b), remainder takes sign of a.
REQ-021 SHALL for DIVS of most-negative value by -1 produce LO = most-negative (wrap), HI = 0, dz=0.
REQ-022 SHALL for DIV with b=0 produce LO = all ones, HI = original a, dz=1, done at edge E0+2.
REQ-023 SHALL deassert done after exactly one cycle; dz holds until the next FIX.
REQ-024 SHALL ignore start while busy=1 (no restart, latched operands unchanged).
REQ-025 SHALL accept start in the cycle done is high (FSM is IDLE then).
REQ-026 SHALL apply hi_wr/lo_wr only when busy=0 and not accepting start on that edge; ignored otherwise; both may write same edge.
REQ-027 SHALL keep hi_out/lo_out unchanged from E0 until the FIX edge.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, busy=0, done=0, dz=0, hi_out=0, lo_out=0, counter=0.
REQ-029 SHALL on reset mid-operation abort it; no done pulse follows; first edge after rst_n rises may accept start.

Verification (WIDTH=16)
REQ-030 SHALL cover MULU a=0xFFFF b=0xFFFF -> hi=0xFFFE lo=0x0001, done at E0+18, dz=0.
REQ-031 SHALL cover MULS a=0xFFFD b=0x0007 -> hi=0xFFFF lo=0xFFEB.
REQ-032 SHALL cover DIVS a=0xFFF9 b=0x0002 -> lo=0xFFFD hi=0xFFFF; DIVS a=0x8000 b=0xFFFF -> lo=0x8000 hi=0x0000.
REQ-033 SHALL cover DIVU a=0x1234 b=0 -> lo=0xFFFF hi=0x1234 dz=1, done at E0+2.
REQ-034 SHALL cover start and hi_wr=1 (wr_data=0xAAAA) asserted mid-RUN -> both ignored, original result delivered; back-to-back start in done cycle accepted.
REQ-035 SHALL cover rst_n pulsed low mid-RUN -> hi=lo=0, busy=0, no done pulse.
